// File: rtl/stitch_pkg.sv
// Shared definitions for the frame-buffer burst scheduler: FSM state encoding
// and the default frame-layout constants.
package stitch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR    = 32'h1000_0000;
  localparam int          DEF_BURST_BYTES  = 1024;
  localparam int          DEF_FRAME_BURSTS = 3600;
  localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0040_0000;

endpackage

// File: rtl/fb_rw_scheduler_if.sv
// Burst command channel between the frame-buffer scheduler (master) and the
// AXI4 burst engine (slave).
interface fb_rw_scheduler_if #(
  parameter int ADDR_WIDTH = 32
) ();

  // A command transfers on the clock edge where cmd_valid && cmd_ready are both
  // high; cmd_valid, cmd_rnw and cmd_addr stay stable from assertion until that
  // edge and cmd_valid never drops without a transfer. cmd_done is a one-cycle
  // pulse per transferred command, and only one command is outstanding.
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rnw;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_done;

  modport master (
    output cmd_valid,
    output cmd_rnw,
    output cmd_addr,
    input  cmd_ready,
    input  cmd_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rnw,
    input  cmd_addr,
    output cmd_ready,
    output cmd_done
  );

endinterface

// File: rtl/fb_rw_scheduler_bank_sel.sv
// Triple-buffer bank bookkeeping: write bank, read bank and the last fully
// written bank, with the writer stepping over the bank the reader holds.
module fb_bank_sel #(
  parameter  int NUM_BUF = 3,
  localparam int BW      = $clog2(NUM_BUF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          apply_wr,
  input  logic          apply_rd,
  input  logic          wr_frame_complete,
  output logic [BW-1:0] wr_bank,
  output logic [BW-1:0] rd_bank,
  output logic [BW-1:0] wr_bank_nxt,
  output logic [BW-1:0] rd_bank_nxt,
  output logic [BW-1:0] last_done
);

  logic [BW-1:0] wr_bank_q, wr_bank_d;
  logic [BW-1:0] rd_bank_q, rd_bank_d;
  logic [BW-1:0] last_done_q, last_done_d;
  logic [BW-1:0] cand;

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    if (int'(b) >= NUM_BUF - 1) return '0;
    return b + BW'(1);
  endfunction

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    last_done_d = last_done_q;
    cand        = bank_inc(wr_bank_q);
    if (cand == rd_bank_q) cand = bank_inc(cand);
    if (apply_wr && wr_frame_complete) begin
      last_done_d = wr_bank_q;
      wr_bank_d   = cand;
    end
    // A read start in the same cycle picks up the frame published just above.
    if (apply_rd) rd_bank_d = last_done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      last_done_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      last_done_q <= last_done_d;
    end
  end

  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign wr_bank_nxt = wr_bank_d;
  assign rd_bank_nxt = rd_bank_d;
  assign last_done   = last_done_q;

endmodule

// File: rtl/fb_rw_scheduler.sv
// Frame-buffer burst scheduler: round-robin between capture writes and display
// reads, one burst outstanding, triple-buffered frame addressing.
module fb_rw_scheduler
  import stitch_pkg::*;
#(
  parameter  logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter  int          ADDR_WIDTH   = 32,
  parameter  int          BURST_BYTES  = DEF_BURST_BYTES,
  parameter  int          FRAME_BURSTS = DEF_FRAME_BURSTS,
  parameter  logic [31:0] FRAME_STRIDE = DEF_FRAME_STRIDE,
  parameter  int          NUM_BUF      = 3,
  localparam int          BW           = $clog2(NUM_BUF),
  localparam int          CW           = $clog2(FRAME_BURSTS + 1)
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESET,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  fb_rw_scheduler_if.master cmd,
  output logic [BW-1:0]     wr_bank,
  output logic [BW-1:0]     rd_bank,
  output logic              frame_drop,
  output state_t            dbg_state,
  output logic [BW-1:0]     dbg_last_done
);

  localparam logic [CW-1:0] FB_MAX = CW'(FRAME_BURSTS);

  state_t                state_q, state_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         wr_cnt_eff, rd_cnt_eff;
  logic                  wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic                  last_rd_q, last_rd_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_rnw_q, cmd_rnw_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic                  frame_drop_q, frame_drop_d;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  apply_wr, apply_rd;
  logic                  wr_elig, rd_elig, grant_rd;
  logic                  wr_frame_complete;
  logic [BW-1:0]         wr_bank_nxt, rd_bank_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= FB_MAX) return FB_MAX;
    return c + CW'(1);
  endfunction

  // Frame starts are applied only in IDLE, before arbitration, so the grant
  // below already sees the new bank and the cleared counter.
  assign apply_wr          = (state_q == IDLE) && (wr_pend_q || wr_frame_start);
  assign apply_rd          = (state_q == IDLE) && (rd_pend_q || rd_frame_start);
  assign wr_frame_complete = (wr_cnt_q == FB_MAX);
  assign wr_cnt_eff        = apply_wr ? '0 : wr_cnt_q;
  assign rd_cnt_eff        = apply_rd ? '0 : rd_cnt_q;
  assign wr_elig           = wr_req && (wr_cnt_eff < FB_MAX);
  assign rd_elig           = rd_req && (rd_cnt_eff < FB_MAX);
  assign grant_rd          = rd_elig && (!wr_elig || !last_rd_q);

  assign wr_addr = ADDR_WIDTH'(BASE_ADDR)
                 + ADDR_WIDTH'(wr_bank_nxt) * ADDR_WIDTH'(FRAME_STRIDE)
                 + ADDR_WIDTH'(wr_cnt_eff) * ADDR_WIDTH'(BURST_BYTES);
  assign rd_addr = ADDR_WIDTH'(BASE_ADDR)
                 + ADDR_WIDTH'(rd_bank_nxt) * ADDR_WIDTH'(FRAME_STRIDE)
                 + ADDR_WIDTH'(rd_cnt_eff) * ADDR_WIDTH'(BURST_BYTES);

  fb_bank_sel #(
    .NUM_BUF (NUM_BUF)
  ) u_bank_sel (
    .clk               (M_AXI_ACLK),
    .rst               (M_AXI_ARESET),
    .apply_wr          (apply_wr),
    .apply_rd          (apply_rd),
    .wr_frame_complete (wr_frame_complete),
    .wr_bank           (wr_bank),
    .rd_bank           (rd_bank),
    .wr_bank_nxt       (wr_bank_nxt),
    .rd_bank_nxt       (rd_bank_nxt),
    .last_done         (dbg_last_done)
  );

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_eff;
    rd_cnt_d     = rd_cnt_eff;
    wr_pend_d    = (wr_pend_q || wr_frame_start) && !apply_wr;
    rd_pend_d    = (rd_pend_q || rd_frame_start) && !apply_rd;
    last_rd_d    = last_rd_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_rnw_d    = cmd_rnw_q;
    cmd_addr_d   = cmd_addr_q;
    frame_drop_d = apply_wr && !wr_frame_complete;
    case (state_q)
      IDLE: begin
        if (wr_elig || rd_elig) begin
          last_rd_d   = grant_rd;
          cmd_rnw_d   = grant_rd;
          cmd_addr_d  = grant_rd ? rd_addr : wr_addr;
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // The completing burst always counts against the frame it was issued in.
        if (cmd.cmd_done) begin
          if (cmd_rnw_q) rd_cnt_d = sat_inc(rd_cnt_q);
          else           wr_cnt_d = sat_inc(wr_cnt_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      last_rd_q    <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_rnw_q    <= 1'b0;
      cmd_addr_q   <= '0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_pend_q    <= wr_pend_d;
      rd_pend_q    <= rd_pend_d;
      last_rd_q    <= last_rd_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_rnw_q    <= cmd_rnw_d;
      cmd_addr_q   <= cmd_addr_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_rnw   = cmd_rnw_q;
  assign cmd.cmd_addr  = cmd_addr_q;
  assign frame_drop    = frame_drop_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fb_rw_scheduler.sv
// Directed bench for fb_rw_scheduler: expected commands queued at stimulus
// time, popped and compared by a monitor on every accepted command.
module tb_fb_rw_scheduler;
  import stitch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_req, rd_req, wr_fs, rd_fs;
  logic [1:0] wr_bank, rd_bank, last_done;
  logic       frame_drop;
  state_t     dbg_state;

  fb_rw_scheduler_if #(.ADDR_WIDTH(32)) bus ();

  fb_rw_scheduler dut (
    .M_AXI_ACLK     (clk),
    .M_AXI_ARESET   (rst),
    .wr_req         (wr_req),
    .rd_req         (rd_req),
    .wr_frame_start (wr_fs),
    .rd_frame_start (rd_fs),
    .cmd            (bus),
    .wr_bank        (wr_bank),
    .rd_bank        (rd_bank),
    .frame_drop     (frame_drop),
    .dbg_state      (dbg_state),
    .dbg_last_done  (last_done)
  );

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int done_dly = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int bank, input int cnt);
    return 32'h1000_0000 + 32'(bank) * 32'h0040_0000 + 32'(cnt) * 32'h400;
  endfunction

  task automatic push_bulk(input bit rnw, input int bank, input int cnt0, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({rnw, exp_addr(bank, cnt0 + i)});
  endtask

  // ---------------- engine model ----------------
  initial begin
    int  eng_cnt;
    bit  eng_busy;
    eng_busy = 1'b0;
    eng_cnt = 0;
    bus.cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.cmd_done = 1'b0;
      if (rst) begin
        eng_busy = 1'b0;
      end else if (eng_busy) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.cmd_done = 1'b1;
          eng_busy = 1'b0;
          done_cnt++;
        end
      end else if (bus.cmd_valid && bus.cmd_ready) begin
        eng_busy = 1'b1;
        eng_cnt = done_dly;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.cmd_valid && bus.cmd_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: actual rnw=%0b addr=0x%0h required=none", bus.cmd_rnw, bus.cmd_addr);
        end else begin
          e = exp_q.pop_front();
          check("cmd", 64'({bus.cmd_rnw, bus.cmd_addr}), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    wr_fs = 1'b0;
    rd_fs = 1'b0;
    bus.cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_and_drop(input int target, input int bound);
    int guard;
    guard = 0;
    while (done_cnt < target && guard < bound) begin
      @(negedge clk);
      guard++;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    check("done_count", 64'(done_cnt), 64'(target));
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input bit do_wr, input bit do_rd, input int n);
    int target;
    target = done_cnt + n;
    wr_req = do_wr;
    rd_req = do_rd;
    wait_and_drop(target, n * 10 + 50);
  endtask

  task automatic pulse_wr_fs();
    wr_fs = 1'b1;
    @(negedge clk);
    wr_fs = 1'b0;
  endtask

  task automatic pulse_rd_fs();
    rd_fs = 1'b1;
    @(negedge clk);
    rd_fs = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int target;
    int acc0;
    int guard;
    do_reset();

    // reset values
    check("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst_cmd_rnw", 64'(bus.cmd_rnw), 64'd0);
    check("rst_cmd_addr", 64'(bus.cmd_addr), 64'd0);
    check("rst_frame_drop", 64'(frame_drop), 64'd0);
    check("rst_wr_bank", 64'(wr_bank), 64'd0);
    check("rst_rd_bank", 64'(rd_bank), 64'd0);
    check("rst_last_done", 64'(last_done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // write only, done 3 cycles after accept
    done_dly = 3;
    exp_q.push_back(33'h0_1000_0000);
    exp_q.push_back(33'h0_1000_0400);
    exp_q.push_back(33'h0_1000_0800);
    target = done_cnt + 3;
    wr_req = 1'b1;
    @(negedge clk);
    check("req_latency", 64'(bus.cmd_valid), 64'd1);
    wait_and_drop(target, 100);

    // both requesting: W,R,W,R
    do_reset();
    exp_q.push_back(33'h0_1000_0000);
    exp_q.push_back(33'h1_1000_0000);
    exp_q.push_back(33'h0_1000_0400);
    exp_q.push_back(33'h1_1000_0400);
    issue(1'b1, 1'b1, 4);

    // full frame into bank 0, then no 3601st grant
    do_reset();
    done_dly = 1;
    push_bulk(1'b0, 0, 0, 3600);
    issue(1'b1, 1'b0, 3600);
    acc0 = acc_cnt;
    wr_req = 1'b1;
    repeat (20) @(negedge clk);
    check("no_grant_3601", 64'(acc_cnt - acc0), 64'd0);
    check("sat_state_idle", 64'(dbg_state), 64'(IDLE));
    wr_req = 1'b0;
    @(negedge clk);
    pulse_wr_fs();
    check("ff_wr_bank", 64'(wr_bank), 64'd1);
    check("ff_last_done", 64'(last_done), 64'd0);
    check("ff_no_drop", 64'(frame_drop), 64'd0);
    exp_q.push_back(33'h0_1040_0000);
    issue(1'b1, 1'b0, 1);
    pulse_rd_fs();
    check("ff_rd_bank", 64'(rd_bank), 64'd0);
    exp_q.push_back(33'h1_1000_0000);
    issue(1'b0, 1'b1, 1);

    // walk banks until reader holds 2 and writer holds 1
    push_bulk(1'b0, 1, 1, 3599);
    issue(1'b1, 1'b0, 3599);
    pulse_wr_fs();
    check("walk1_wr_bank", 64'(wr_bank), 64'd2);
    check("walk1_last_done", 64'(last_done), 64'd1);
    push_bulk(1'b0, 2, 0, 3600);
    issue(1'b1, 1'b0, 3600);
    pulse_wr_fs();
    check("walk2_wr_bank", 64'(wr_bank), 64'd1);
    check("walk2_last_done", 64'(last_done), 64'd2);
    pulse_rd_fs();
    check("walk2_rd_bank", 64'(rd_bank), 64'd2);

    // skip the reader's bank
    push_bulk(1'b0, 1, 0, 3600);
    issue(1'b1, 1'b0, 3600);
    pulse_wr_fs();
    check("skip_wr_bank", 64'(wr_bank), 64'd0);
    check("skip_last_done", 64'(last_done), 64'd1);
    check("skip_rd_bank_kept", 64'(rd_bank), 64'd2);
    exp_q.push_back(33'h0_1000_0000);
    issue(1'b1, 1'b0, 1);
    pulse_rd_fs();
    check("skip_rd_bank", 64'(rd_bank), 64'd1);
    exp_q.push_back(33'h1_1040_0000);
    issue(1'b0, 1'b1, 1);

    // incomplete frame
    do_reset();
    push_bulk(1'b0, 0, 0, 100);
    issue(1'b1, 1'b0, 100);
    pulse_wr_fs();
    check("drop_pulse", 64'(frame_drop), 64'd1);
    check("drop_wr_bank", 64'(wr_bank), 64'd0);
    @(negedge clk);
    check("drop_one_cycle", 64'(frame_drop), 64'd0);
    exp_q.push_back(33'h0_1000_0000);
    issue(1'b1, 1'b0, 1);

    // frame start during WAIT_DONE
    do_reset();
    done_dly = 5;
    exp_q.push_back(33'h0_1000_0000);
    wr_req = 1'b1;
    guard = 0;
    while (dbg_state != WAIT_DONE && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("wd_reached", 64'(dbg_state), 64'(WAIT_DONE));
    wr_req = 1'b0;
    pulse_wr_fs();
    check("wd_held", 64'(dbg_state), 64'(WAIT_DONE));
    check("wd_no_early_drop", 64'(frame_drop), 64'd0);
    guard = 0;
    while (dbg_state != IDLE && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("wd_back_idle", 64'(dbg_state), 64'(IDLE));
    check("wd_drop_not_yet", 64'(frame_drop), 64'd0);
    @(negedge clk);
    check("wd_drop_pulse", 64'(frame_drop), 64'd1);
    check("wd_wr_bank", 64'(wr_bank), 64'd0);
    @(negedge clk);
    check("wd_drop_end", 64'(frame_drop), 64'd0);
    done_dly = 1;
    exp_q.push_back(33'h0_1000_0000);
    issue(1'b1, 1'b0, 1);

    // reset during ISSUE
    do_reset();
    exp_q.push_back(33'h0_1000_0000);
    issue(1'b1, 1'b0, 1);
    exp_q.push_back(33'h0_1000_0400);
    issue(1'b1, 1'b0, 1);
    exp_q.push_back(33'h1_1000_0000);
    issue(1'b0, 1'b1, 1);
    bus.cmd_ready = 1'b0;
    wr_req = 1'b1;
    @(negedge clk);
    check("stall_valid", 64'(bus.cmd_valid), 64'd1);
    @(negedge clk);
    check("stall_state", 64'(dbg_state), 64'(ISSUE));
    check("stall_addr", 64'(bus.cmd_addr), 64'h1000_0800);
    rst = 1'b1;
    wr_req = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("mid_rst_addr", 64'(bus.cmd_addr), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    exp_q.push_back(33'h0_1000_0000);
    issue(1'b1, 1'b0, 1);
    exp_q.push_back(33'h1_1000_0000);
    issue(1'b0, 1'b1, 1);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_rw_scheduler.md
# fb_rw_scheduler

- Frame-buffer burst scheduler in front of the stitching top's AXI4 master burst engine.
- Arbitrates between the capture side (write FIFO holds at least one burst) and the display side (read FIFO has room for one burst), with round-robin priority.
- Generates each burst's DDR address from a triple-buffered frame layout.
- Publishes only fully written frames to the reader, so the display never reads a frame still being written.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of bank 0
- ADDR_WIDTH, 32, width of cmd_addr
- BURST_BYTES, 1024, bytes per burst (64 beats × 128 bit)
- FRAME_BURSTS, 3600, bursts per frame (1280×720×4 B / 1024)
- FRAME_STRIDE, 32'h0040_0000, byte distance between banks
- NUM_BUF, 3, number of frame banks (≥3)

Ports:
- M_AXI_ACLK  in  1  single clock for the whole block
- M_AXI_ARESET  in  1  reset, synchronous, active-high
- wr_req  in  1  level; write FIFO holds ≥ BURST_BYTES
- rd_req  in  1  level; read FIFO has room ≥ BURST_BYTES
- wr_frame_start  in  1  one-cycle pulse; capture vsync, already in this domain
- rd_frame_start  in  1  one-cycle pulse; display vsync, already in this domain
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  engine accepts command
- cmd_rnw  out  1  1 = read burst, 0 = write burst
- cmd_addr  out  ADDR_WIDTH  burst start byte address
- cmd_done  in  1  one-cycle pulse; engine finished the accepted burst (BRESP or RLAST)
- wr_bank  out  $clog2(NUM_BUF)  bank currently being written
- rd_bank  out  $clog2(NUM_BUF)  bank currently being read
- frame_drop  out  1  one-cycle pulse; an incomplete write frame was discarded

## Operation
- FSM has three states: IDLE, ISSUE, WAIT_DONE.
- **IDLE**
  - First, apply any pending frame starts (write first, then read).
  - Then arbitrate between eligible requesters.
  - Write is eligible when wr_req=1 and wr_cnt < FRAME_BURSTS. Read is eligible when rd_req=1 and rd_cnt < FRAME_BURSTS.
  - If both are eligible, grant the one not granted last; last_grant resets to "read", so write wins first.
  - On a grant: register cmd_rnw and cmd_addr, set cmd_valid=1, go to ISSUE.
- **ISSUE**
  - Hold cmd_valid, cmd_rnw and cmd_addr stable until cmd_ready=1, then drop cmd_valid and go to WAIT_DONE.
- **WAIT_DONE**
  - On cmd_done, increment the granted side's counter (wr_cnt or rd_cnt) and go to IDLE.
  - cmd_done is ignored in IDLE and ISSUE.
  - Only one burst is outstanding at any time.
- Address = BASE_ADDR + bank×FRAME_STRIDE + cnt×BURST_BYTES, computed at full ADDR_WIDTH with the upper bits truncated.
- wr_frame_start is latched as pending. When applied in IDLE:
  - If wr_cnt == FRAME_BURSTS: last_done ← wr_bank, and wr_bank ← (wr_bank+1) mod NUM_BUF; if that value equals rd_bank, add 1 more (mod NUM_BUF).
  - Otherwise: pulse frame_drop and keep wr_bank.
  - In both cases wr_cnt ← 0.
- rd_frame_start is latched as pending. When applied in IDLE: rd_bank ← last_done and rd_cnt ← 0.
  - Because write applies first, a read start in the same cycle sees a just-published frame.
- Counters saturate at FRAME_BURSTS; requests beyond that are not granted until the next frame start.
- A repeated frame-start pulse while one is already pending merges with it.

## Timing
- Reset values:
  - cmd_valid=0, cmd_rnw=0, cmd_addr=0, frame_drop=0.
  - wr_bank=0, rd_bank=0, last_done=0, wr_cnt=0, rd_cnt=0.
  - Pending flags cleared, last_grant=read, state IDLE.
- Request latency: a request seen in IDLE at cycle N gives cmd_valid=1 at N+1.
- After cmd_done at cycle N: state is IDLE at N+1, and the next cmd_valid is no earlier than N+2.
- A frame start arriving in ISSUE or WAIT_DONE waits for the next IDLE cycle. The in-flight burst is counted against the old frame.
- frame_drop pulses exactly one cycle, in the cycle after the IDLE cycle that applies the start.
- Reset in any state, including mid-ISSUE: all outputs take their reset values on the next edge; the in-flight command is abandoned.

## Structure
- Shared package stitch_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_DONE);
  - default localparams for BASE_ADDR, BURST_BYTES, FRAME_BURSTS, FRAME_STRIDE.
- One sub-module: fb_bank_sel. It holds the bank registers, last_done and the skip-reader next-bank logic. It takes apply-write and apply-read strobes and a "write frame complete" flag.

## Test plan
- **Write only:** reset, then hold wr_req=1 with cmd_ready=1 and cmd_done 3 cycles after accept → cmd_addr 0x1000_0000, 0x1000_0400, 0x1000_0800, all with rnw=0.
- **Both requesting:** wr_req=rd_req=1 continuously → grant order W,R,W,R. Read addresses are 0x1000_0000, 0x1000_0400 (bank 0).
- **Full frame:** complete 3600 write bursts, then pulse wr_frame_start → wr_bank=1, next write addr 0x1040_0000. Then pulse rd_frame_start → rd_bank=0, read addr 0x1000_0000.
- **Skip reader bank:** with rd_bank=2 and wr_bank=1, complete a frame and pulse wr_frame_start → wr_bank=0 (bank 2 skipped), last_done=1.
- **Incomplete frame:** pulse wr_frame_start after 100 bursts → frame_drop for 1 cycle, wr_bank unchanged, next write addr back at bank base. Also verify a 3601st wr_req gets no grant.
- **Boundary events:**
  - wr_frame_start during WAIT_DONE → applied the cycle after cmd_done, and the in-flight burst is counted in the old frame.
  - Reset during ISSUE → cmd_valid=0 next cycle and all counters at 0.
